// File: rtl/joybus_tx.sv
// JOYBUS console command transmitter: serialises a left-aligned command word
// in 4 us bit cells, appends the stop bit, then pulses rx_start to hand off to the receiver.
module joybus_tx #(
    parameter int CYC_PER_US   = 50,
    parameter int RX_START_DLY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [23:0] tx_data,
    input  logic [4:0]  tx_len,
    output logic        JB_TX,
    output logic        tx_busy,
    output logic        rx_start
);

    // state     | meaning
    // IDLE      | line released, waiting for a request
    // LOW       | low part of a data cell (1 us for a 1, 3 us for a 0)
    // HIGH      | released remainder of the data cell
    // STOP_LOW  | 1 us console stop bit
    // STOP_WAIT | released line before rx_start fires
    typedef enum logic [2:0] {IDLE, LOW, HIGH, STOP_LOW, STOP_WAIT} state_t;

    localparam int CELL    = 4 * CYC_PER_US;
    localparam int PW_CELL = $clog2(CELL + 1);
    localparam int PW_DLY  = $clog2(RX_START_DLY + 1);
    // Widened only if the handoff delay would not fit the cell-sized counter
    localparam int PW      = (PW_DLY > PW_CELL) ? PW_DLY : PW_CELL;

    localparam logic [PW-1:0] SHORT_END = PW'(CYC_PER_US - 1);
    localparam logic [PW-1:0] LONG_END  = PW'(3 * CYC_PER_US - 1);
    localparam logic [PW-1:0] DLY_END   = PW'(RX_START_DLY);

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [23:0]   shreg, shreg_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [PW-1:0] low_end, high_end;

    assign low_end  = shreg[23] ? SHORT_END : LONG_END;
    assign high_end = shreg[23] ? LONG_END  : SHORT_END;
    assign tx_busy  = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase + PW'(1);
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        rx_start    = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (tx_start && (tx_len != 5'd0)) begin
                    state_nxt   = LOW;
                    shreg_nxt   = tx_data;
                    bit_cnt_nxt = (tx_len > 5'd24) ? 5'd24 : tx_len;
                end
            end
            LOW: begin
                if (phase == low_end) begin
                    state_nxt = HIGH;
                    phase_nxt = '0;
                end
            end
            HIGH: begin
                if (phase == high_end) begin
                    shreg_nxt   = {shreg[22:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - 5'd1;
                    phase_nxt   = '0;
                    state_nxt   = (bit_cnt == 5'd1) ? STOP_LOW : LOW;
                end
            end
            STOP_LOW: begin
                if (phase == SHORT_END) begin
                    state_nxt = STOP_WAIT;
                    phase_nxt = '0;
                end
            end
            STOP_WAIT: begin
                if (phase == DLY_END) begin
                    rx_start  = 1'b1;
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            JB_TX   <= 1'b1;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            // Pad level follows the state being entered so it lines up with the state register
            JB_TX   <= !((state_nxt == LOW) || (state_nxt == STOP_LOW));
        end
    end

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx: table of frames checked cycle by cycle against
// a bit-cell waveform model, plus busy-protection and mid-frame reset sequences.
module tb_joybus_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [23:0] tx_data;
    logic [4:0]  tx_len;
    logic        jb0, busy0, rx0, jb1, busy1, rx1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    joybus_tx #(.CYC_PER_US(50), .RX_START_DLY(0)) dut0 (
        .clk(clk), .rst(rst), .tx_start(start0), .tx_data(tx_data), .tx_len(tx_len),
        .JB_TX(jb0), .tx_busy(busy0), .rx_start(rx0)
    );

    joybus_tx #(.CYC_PER_US(25), .RX_START_DLY(40)) dut1 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_data(tx_data), .tx_len(tx_len),
        .JB_TX(jb1), .tx_busy(busy1), .rx_start(rx1)
    );

    typedef struct {
        bit          sel;
        logic [23:0] data;
        logic [4:0]  len;
        int          cells;
        int          exp_rx;
        int          exp_busy;
        bit          poke;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int cpu, dly, c4, last, n;
        int rx_cnt, rx_at, busy_cnt, wave_bad, first_bad;
        logic jb, busy, rx, ejb, ebusy, erx, b;
        cpu = v.sel ? 25 : 50;
        dly = v.sel ? 40 : 0;
        c4  = 4 * cpu;
        n   = v.cells;
        last = (n == 0) ? 300 : (v.poke ? v.exp_rx + 2 : v.exp_rx + 3);
        rx_cnt = 0; rx_at = 0; busy_cnt = 0; wave_bad = 0; first_bad = 0;

        @(posedge clk); #1;
        tx_data = v.data;
        tx_len  = v.len;
        if (v.sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (n != 0) begin
            tx_data = ~v.data;
            tx_len  = 5'd3;
        end

        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            jb   = v.sel ? jb1   : jb0;
            busy = v.sel ? busy1 : busy0;
            rx   = v.sel ? rx1   : rx0;
            if (v.poke && i == v.exp_rx + 2) begin
                check({v.name, "_turnaround_jb"}, int'(jb), 0);
                check({v.name, "_turnaround_busy"}, int'(busy), 1);
            end else begin
                if (n == 0) begin
                    ejb = 1'b1; ebusy = 1'b0; erx = 1'b0;
                end else if (i <= c4 * n) begin
                    b     = v.data[23 - (i - 1) / c4];
                    ejb   = ((i - 1) % c4) >= (b ? cpu : 3 * cpu);
                    ebusy = 1'b1; erx = 1'b0;
                end else if (i <= c4 * n + cpu) begin
                    ejb = 1'b0; ebusy = 1'b1; erx = 1'b0;
                end else if (i <= c4 * n + cpu + dly + 1) begin
                    ejb = 1'b1; ebusy = 1'b1; erx = (i == c4 * n + cpu + dly + 1);
                end else begin
                    ejb = 1'b1; ebusy = 1'b0; erx = 1'b0;
                end
                if ({jb, busy, rx} !== {ejb, ebusy, erx}) begin
                    wave_bad++;
                    if (first_bad == 0) first_bad = i;
                end
                if (rx === 1'b1) begin
                    rx_cnt++;
                    rx_at = i;
                end
                if (busy === 1'b1) busy_cnt++;
            end
            if (v.poke)
                start0 = (i == 10 || i == 500 || i == v.exp_rx || i == v.exp_rx + 1);
        end
        start0 = 1'b0;

        check({v.name, "_wave_bad_cycles"}, wave_bad, 0);
        if (wave_bad != 0) $display("  %s first deviating cycle %0d", v.name, first_bad);
        check({v.name, "_rx_count"}, rx_cnt, (n == 0) ? 0 : 1);
        check({v.name, "_rx_cycle"}, rx_at, v.exp_rx);
        check({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);

        if (v.poke) begin
            int k;
            k = 0;
            while (busy0 !== 1'b0 && k < 5000) begin
                @(negedge clk);
                k++;
            end
            check({v.name, "_drain_busy"}, int'(busy0), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx_seen;
        vecs[0] = '{1'b0, 24'h010000, 5'd8,  8,  1651, 1651, 1'b0, "n64_poll"};
        vecs[1] = '{1'b0, 24'h400300, 5'd24, 24, 4851, 4851, 1'b0, "gc_poll"};
        vecs[2] = '{1'b0, 24'h400300, 5'd31, 24, 4851, 4851, 1'b0, "len31_clamp"};
        vecs[3] = '{1'b0, 24'h800000, 5'd1,  1,  251,  251,  1'b0, "len1_one"};
        vecs[4] = '{1'b0, 24'hFFFFFF, 5'd0,  0,  0,    0,    1'b0, "len0_ignored"};
        vecs[5] = '{1'b1, 24'h010000, 5'd8,  8,  866,  866,  1'b0, "param_sweep"};
        vecs[6] = '{1'b0, 24'hA5A5A5, 5'd24, 24, 4851, 4851, 1'b0, "mixed_bits"};
        vecs[7] = '{1'b0, 24'h010000, 5'd8,  8,  1651, 1651, 1'b1, "busy_protect"};

        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        tx_data = '0;
        tx_len = '0;
        repeat (3) @(negedge clk);
        check("reset_jb", int'(jb0), 1);
        check("reset_busy", int'(busy0), 0);
        check("reset_rx", int'(rx0), 0);
        check("reset_jb_sweep", int'(jb1), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 8; t++) run_frame(vecs[t]);

        // Mid-frame reset during the low phase of cell 3 (cycles 601..750)
        @(posedge clk); #1;
        tx_data = 24'h010000;
        tx_len  = 5'd8;
        start0  = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (650) @(negedge clk);
        check("pre_reset_jb_low", int'(jb0), 0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_jb", int'(jb0), 1);
        check("async_reset_busy", int'(busy0), 0);
        rx_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx0 === 1'b1) rx_seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx0 === 1'b1 || jb0 !== 1'b1) rx_seen++;
        end
        check("reset_no_rx_no_activity", rx_seen, 0);

        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
